// File: rtl/cic_interp.sv
// N-stage CIC interpolator. The combs run at clk/R on a slot strobe and are
// zero-stuffed into full-precision integrators that update on every clk cycle.
module cic_interp #(
  parameter  int IN_W  = 16,
  parameter  int N     = 4,
  parameter  int LOG2R = 3,
  localparam int OUT_W = IN_W + (N - 1) * LOG2R
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [IN_W-1:0]  din,
  output logic             din_ready,
  output logic             dout_valid,
  output logic [OUT_W-1:0] dout,
  output logic             underrun
);

  localparam int TAG_LEN = 2 * N - 1;

  logic [LOG2R-1:0]   cnt_q, cnt_d;
  logic [N-1:0]       strobe_q, strobe_d;   // strobe_q[k-1] is slot strobe s_k
  logic [TAG_LEN-1:0] tag_q, tag_d;
  logic               dout_valid_q, dout_valid_d;
  logic               underrun_q, underrun_d;

  logic [OUT_W-1:0] comb_q  [N];
  logic [OUT_W-1:0] comb_d  [N];
  logic [OUT_W-1:0] dly_q   [N];
  logic [OUT_W-1:0] dly_d   [N];
  logic [OUT_W-1:0] integ_q [N];
  logic [OUT_W-1:0] integ_d [N];

  logic [OUT_W-1:0] stage_in [N];
  logic [N-1:0]     stage_en;
  logic             s0;
  logic [OUT_W-1:0] sample;
  logic [OUT_W-1:0] x;

  assign s0     = (cnt_q == '0);
  assign sample = din_valid ? OUT_W'($signed(din)) : '0;

  // Comb stage k is fed by comb k-1 and fires one cycle behind it.
  for (genvar gi = 0; gi < N; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_in[gi] = sample;
      assign stage_en[gi] = s0;
    end else begin : g_rest
      assign stage_in[gi] = comb_q[gi-1];
      assign stage_en[gi] = strobe_q[gi-1];
    end
  end

  always_comb begin
    cnt_d        = cnt_q + 1'b1;
    strobe_d     = {strobe_q[N-2:0], s0};
    tag_d        = {tag_q[TAG_LEN-2:0], s0 & din_valid};
    dout_valid_d = dout_valid_q | tag_q[TAG_LEN-1];
    underrun_d   = s0 & ~din_valid;

    comb_d = comb_q;
    dly_d  = dly_q;
    for (int k = 0; k < N; k++) begin
      if (stage_en[k]) begin
        dly_d[k]  = stage_in[k];
        comb_d[k] = stage_in[k] - dly_q[k];
      end
    end

    // Zero stuffing: the last comb output is seen by the integrators for one cycle per slot.
    x = strobe_q[N-1] ? comb_q[N-1] : '0;
    integ_d[0] = integ_q[0] + x;
    for (int k = 1; k < N; k++) begin
      integ_d[k] = integ_q[k] + integ_q[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q        <= '1;
      strobe_q     <= '0;
      tag_q        <= '0;
      dout_valid_q <= 1'b0;
      underrun_q   <= 1'b0;
      for (int k = 0; k < N; k++) begin
        comb_q[k]  <= '0;
        dly_q[k]   <= '0;
        integ_q[k] <= '0;
      end
    end else begin
      cnt_q        <= cnt_d;
      strobe_q     <= strobe_d;
      tag_q        <= tag_d;
      dout_valid_q <= dout_valid_d;
      underrun_q   <= underrun_d;
      for (int k = 0; k < N; k++) begin
        comb_q[k]  <= comb_d[k];
        dly_q[k]   <= dly_d[k];
        integ_q[k] <= integ_d[k];
      end
    end
  end

  assign din_ready  = s0;
  assign dout       = integ_q[N-1];
  assign dout_valid = dout_valid_q;
  assign underrun   = underrun_q;

endmodule

// File: tb/tb_cic_interp.sv
// Randomised bench for cic_interp: outputs are predicted by convolving the slot
// inputs with the boxcar^N impulse response, in plain 64-bit arithmetic.
module tb_cic_interp;

  localparam int IN_W  = 16;
  localparam int N     = 4;
  localparam int LOG2R = 3;
  localparam int R     = 8;
  localparam int OUT_W = IN_W + (N - 1) * LOG2R;
  localparam int HLEN  = N * (R - 1) + 1;
  localparam int LAT   = 2 * N;
  localparam int MEM   = 1024;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din_valid = 1'b0;
  logic [IN_W-1:0]  din = '0;
  logic             din_ready;
  logic             dout_valid;
  logic [OUT_W-1:0] dout;
  logic             underrun;

  cic_interp #(.IN_W(IN_W), .N(N), .LOG2R(LOG2R)) dut (
    .clk        (clk),
    .rst        (rst),
    .din_valid  (din_valid),
    .din        (din),
    .din_ready  (din_ready),
    .dout_valid (dout_valid),
    .dout       (dout),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc;
  longint h [HLEN];

  longint exp_mem [MEM];
  int     first_acc;
  bit     under_pend;

  longint hist [MEM];
  int     ucount, ufirst, ulast;

  always @(posedge clk or negedge rst) begin
    if (!rst) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic longint wrap_out(input longint v);
    logic [OUT_W-1:0] b;
    b = v[OUT_W-1:0];
    return longint'($signed(b));
  endfunction

  // Reference: every slot (cycle t with t mod R == 1) deposits u*h[j] at cycle t+LAT+j.
  always @(negedge clk) begin : cmp
    int     t;
    bit     slot;
    longint u;
    if (!rst) begin
      check("rst_dout", longint'($signed(dout)), 0);
      check("rst_dout_valid", dout_valid, 0);
      check("rst_din_ready", din_ready, 0);
      check("rst_underrun", underrun, 0);
      for (int i = 0; i < MEM; i++) exp_mem[i] = 0;
      first_acc  = -1;
      under_pend = 1'b0;
    end else begin
      t    = cyc;
      slot = (t % R == 1);
      check("din_ready", din_ready, slot);
      check("underrun", underrun, under_pend);
      if (t < MEM) check("dout", longint'($signed(dout)), wrap_out(exp_mem[t]));
      check("dout_valid", dout_valid, (first_acc >= 0 && t >= first_acc + LAT));
      under_pend = slot && !din_valid;
      if (slot) begin
        u = din_valid ? longint'($signed(din)) : 0;
        if (din_valid && first_acc < 0) first_acc = t;
        for (int j = 0; j < HLEN; j++) begin
          if (t + LAT + j < MEM) exp_mem[t+LAT+j] += u * h[j];
        end
      end
    end
  end

  task automatic pattern(input int kind, input int m, output bit v, output logic [IN_W-1:0] d);
    v = 1'b1;
    d = '0;
    case (kind)
      0: d = (m == 0) ? IN_W'(1) : IN_W'(0);
      1: d = IN_W'(100);
      2: d = IN_W'(16'h8000);
      3: d = m[0] ? IN_W'(16'h8000) : IN_W'(16'h7fff);
      4: begin v = !(m == 5 || m == 6); d = IN_W'(100); end
      default: begin v = ($urandom % 4) != 0; d = IN_W'($urandom); end
    endcase
  endtask

  // Reset the DUT (possibly mid-stream), then drive ncyc cycles of the chosen pattern.
  task automatic run(input string label, input int kind, input int nslots, input int ncyc,
                     input bit chk_end, input longint end_val);
    bit              v;
    logic [IN_W-1:0] d;
    int              m;
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b1; din = IN_W'($urandom);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < MEM; i++) hist[i] = 0;
    ucount = 0; ufirst = -1; ulast = -1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (cyc < MEM) hist[cyc] = longint'($signed(dout));
      if (underrun) begin
        ucount++;
        if (ucount == 1) ufirst = cyc;
        ulast = cyc;
      end
      if (cyc % R == 1) begin
        m = (cyc - 1) / R;
        if (m < nslots) pattern(kind, m, v, d);
        else begin v = 1'b1; d = '0; end
        din_valid = v; din = d;
      end else begin
        din_valid = 1'($urandom_range(0, 1));
        din = IN_W'($urandom);
      end
    end
    if (chk_end) check({label, "_end"}, longint'($signed(dout)), end_val);
    $display("segment %s: %0d cycles, %0d checks so far", label, ncyc, checks);
  endtask

  // Impulse accepted in cycle 1 appears from cycle 9 onward.
  task automatic impulse_literals(input string label);
    longint sum;
    int     nz, last;
    sum = 0; nz = 0; last = -1;
    for (int i = 0; i < MEM; i++) begin
      sum += hist[i];
      if (hist[i] != 0) begin nz++; last = i; end
    end
    check({label, "_c8"},  hist[8],  0);
    check({label, "_c9"},  hist[9],  1);
    check({label, "_c10"}, hist[10], 4);
    check({label, "_c11"}, hist[11], 10);
    check({label, "_c16"}, hist[16], 120);
    check({label, "_sum"}, sum, 4096);
    check({label, "_nonzero"}, nz, 29);
    check({label, "_last"}, last, 37);
  endtask

  initial begin : drive
    longint nxt [HLEN];
    longint pin [8];
    longint s;
    int     nz;

    for (int i = 0; i < HLEN; i++) h[i] = 0;
    h[0] = 1;
    for (int st = 0; st < N; st++) begin
      for (int i = 0; i < HLEN; i++) begin
        nxt[i] = 0;
        for (int k = 0; k < R; k++) if (i - k >= 0) nxt[i] += h[i-k];
      end
      h = nxt;
    end
    pin = '{1, 4, 10, 20, 35, 56, 84, 120};
    for (int i = 0; i < 8; i++) check("model_h", h[i], pin[i]);
    s = 0; nz = 0;
    for (int i = 0; i < HLEN; i++) begin s += h[i]; if (h[i] != 0) nz++; end
    check("model_sum", s, 4096);
    check("model_len", nz, 29);
    check("model_phase_gain", h[0] + h[8] + h[16] + h[24], 512);

    #1 rst = 1'b0;
    din_valid = 1'b1;
    repeat (4) @(posedge clk);
    #1 din = IN_W'($urandom);

    run("impulse", 0, 1, 48, 1'b0, 0);
    impulse_literals("impulse");
    run("dc100", 1, 12, 96, 1'b1, 51200);
    run("dc_neg", 2, 12, 96, 1'b1, -16777216);
    run("alternate", 3, 64, 552, 1'b0, 0);
    run("underrun", 4, 12, 96, 1'b1, 51200);
    check("underrun_count", ucount, 2);
    check("underrun_first", ufirst, 42);
    check("underrun_last", ulast, 50);
    run("random", 5, 40, 360, 1'b0, 0);
    run("partial_impulse", 0, 1, 16, 1'b0, 0);
    run("impulse_again", 0, 1, 48, 1'b0, 0);
    impulse_literals("impulse_again");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
